// File: rtl/transmissor_pkg.sv
// rtl/transmissor_pkg.sv - shared state encoding, parity modes and frame sizing for transmissor_serial
package transmissor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        START,
        DADOS,
        PARIDADE,
        STOP,
        ESPERA_SOLTAR
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Number of bit slots in one frame: start, payload, optional parity, stop(s)
    function automatic int frame_bits(input int data_w, input int instr_w,
                                      input int parity, input int stop_bits);
        return 1 + data_w + instr_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

    // Frame duration in clock cycles
    function automatic int frame_len(input int data_w, input int instr_w, input int clks_per_bit,
                                     input int parity, input int stop_bits);
        return clks_per_bit * frame_bits(data_w, instr_w, parity, stop_bits);
    endfunction

endpackage

// File: rtl/transmissor_serial_if.sv
// rtl/transmissor_serial_if.sv - request/payload/line bundle between a requester and transmissor_serial
interface transmissor_serial_if #(
    parameter int DATA_W  = 4,
    parameter int INSTR_W = 4
);
    logic               botao;
    logic [DATA_W-1:0]  dado;
    logic [INSTR_W-1:0] instrucao;
    logic               out;
    logic               ocupado;
    logic               pronto;

    modport master (
        output botao,
        output dado,
        output instrucao,
        input  out,
        input  ocupado,
        input  pronto
    );

    modport slave (
        input  botao,
        input  dado,
        input  instrucao,
        output out,
        output ocupado,
        output pronto
    );
endinterface

// File: rtl/transmissor_serial_debouncer.sv
// rtl/transmissor_serial_debouncer.sv - button debounce and one-frame-per-press gating
module debouncer_botao
    import transmissor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clock,
    input  logic reset_n,
    input  logic botao,
    input  logic frame_done,
    output logic accept
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

    // START here stands for "a frame is in flight"; the frame FSM owns the finer states.
    state_t        st;
    logic [DW-1:0] deb_cnt;

    // accept fires on the cycle whose sample is the DEBOUNCE_CYCLES-th consecutive high one,
    // so the frame FSM can drop the line on that very edge.
    assign accept = botao &&
                    (((st == IDLE) && (DEBOUNCE_CYCLES == 1)) ||
                     ((st == DEBOUNCE) && (deb_cnt == CNT_LAST)));

    // Request qualification: count consecutive highs, hold off during a frame, wait for release after it
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            st      <= IDLE;
            deb_cnt <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (botao) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            st <= START;
                        end else begin
                            st      <= DEBOUNCE;
                            deb_cnt <= DW'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!botao) begin
                        st      <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == CNT_LAST) begin
                        st      <= START;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                START: begin
                    if (frame_done) begin
                        st <= botao ? ESPERA_SOLTAR : IDLE;
                    end
                end
                ESPERA_SOLTAR: begin
                    if (!botao) begin
                        st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/transmissor_serial.sv
// rtl/transmissor_serial.sv - button-triggered LSB-first serial frame transmitter
module transmissor_serial
    import transmissor_pkg::*;
#(
    parameter int DATA_W          = 4,
    parameter int INSTR_W         = 4,
    parameter int CLKS_PER_BIT    = 1,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    transmissor_serial_if.slave bus
);

    localparam int PAY_W = DATA_W + INSTR_W;
    localparam int NBITS = frame_bits(DATA_W, INSTR_W, PARITY, STOP_BITS);
    localparam int FLEN  = frame_len(DATA_W, INSTR_W, CLKS_PER_BIT, PARITY, STOP_BITS);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W = $clog2(FLEN + 1);

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST_PAY = IDX_W'(PAY_W);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NBITS - 1);

    state_t             st;
    logic [PAY_W-1:0]   shreg;
    logic               par_bit;
    logic [CNT_W-1:0]   bit_cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic               out_r;
    logic               ocupado_r;
    logic               pronto_r;

    logic               accept;
    logic               bit_end;
    logic               frame_done;
    logic [PAY_W-1:0]   payload;

    assign payload    = {bus.instrucao, bus.dado};
    assign bit_end    = (bit_cnt == CNT_LAST);
    assign frame_done = (st == STOP) && bit_end && (bit_idx == IDX_LAST);

    assign bus.out     = out_r;
    assign bus.ocupado = ocupado_r;
    assign bus.pronto  = pronto_r;

    debouncer_botao #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock      (clock),
        .reset_n    (reset_n),
        .botao      (bus.botao),
        .frame_done (frame_done),
        .accept     (accept)
    );

    // Frame sequencer: bit_idx names the frame slot currently on the line (0 = start bit)
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            st        <= IDLE;
            shreg     <= '0;
            par_bit   <= 1'b0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            out_r     <= 1'b1;
            ocupado_r <= 1'b0;
            pronto_r  <= 1'b0;
        end else begin
            pronto_r <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (accept) begin
                        shreg     <= payload;
                        par_bit   <= (PARITY == PAR_ODD) ? ~(^payload) : (^payload);
                        bit_cnt   <= '0;
                        bit_idx   <= '0;
                        out_r     <= 1'b0;
                        ocupado_r <= 1'b1;
                        st        <= START;
                    end
                end
                START, DADOS, PARIDADE, STOP: begin
                    if (!bit_end) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        bit_cnt <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        unique case (st)
                            START: begin
                                out_r <= shreg[0];
                                shreg <= shreg >> 1;
                                st    <= DADOS;
                            end
                            DADOS: begin
                                if (bit_idx == IDX_LAST_PAY) begin
                                    if (PARITY != PAR_NONE) begin
                                        out_r <= par_bit;
                                        st    <= PARIDADE;
                                    end else begin
                                        out_r <= 1'b1;
                                        st    <= STOP;
                                    end
                                end else begin
                                    out_r <= shreg[0];
                                    shreg <= shreg >> 1;
                                end
                            end
                            PARIDADE: begin
                                out_r <= 1'b1;
                                st    <= STOP;
                            end
                            STOP: begin
                                if (bit_idx == IDX_LAST) begin
                                    bit_idx   <= '0;
                                    ocupado_r <= 1'b0;
                                    pronto_r  <= 1'b1;
                                    st        <= IDLE;
                                end
                            end
                            default: st <= IDLE;
                        endcase
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transmissor_serial.sv
// tb/tb_transmissor_serial.sv - self-checking bench for transmissor_serial across several parameter sets
module tb_transmissor_serial;

    localparam int MAXN = 256;
    localparam int NI   = 5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cdw  [NI] = '{4, 4, 4, 4, 3};
    int ciw  [NI] = '{4, 4, 4, 4, 5};
    int ccpb [NI] = '{1, 4, 4, 2, 3};
    int cdeb [NI] = '{3, 3, 3, 3, 1};
    int cpar [NI] = '{0, 1, 2, 1, 2};
    int cstop[NI] = '{1, 1, 1, 2, 2};

    logic       botao_v [NI];
    logic       rst_v   [NI];
    logic [7:0] dado_v  [NI];
    logic [7:0] instr_v [NI];
    logic [2:0] obs_w   [NI];

    transmissor_serial_if #(.DATA_W(4), .INSTR_W(4)) if0 ();
    transmissor_serial_if #(.DATA_W(4), .INSTR_W(4)) if1 ();
    transmissor_serial_if #(.DATA_W(4), .INSTR_W(4)) if2 ();
    transmissor_serial_if #(.DATA_W(4), .INSTR_W(4)) if3 ();
    transmissor_serial_if #(.DATA_W(3), .INSTR_W(5)) if4 ();

    assign if0.botao = botao_v[0]; assign if0.dado = dado_v[0][3:0]; assign if0.instrucao = instr_v[0][3:0];
    assign if1.botao = botao_v[1]; assign if1.dado = dado_v[1][3:0]; assign if1.instrucao = instr_v[1][3:0];
    assign if2.botao = botao_v[2]; assign if2.dado = dado_v[2][3:0]; assign if2.instrucao = instr_v[2][3:0];
    assign if3.botao = botao_v[3]; assign if3.dado = dado_v[3][3:0]; assign if3.instrucao = instr_v[3][3:0];
    assign if4.botao = botao_v[4]; assign if4.dado = dado_v[4][2:0]; assign if4.instrucao = instr_v[4][4:0];

    assign obs_w[0] = {if0.out, if0.ocupado, if0.pronto};
    assign obs_w[1] = {if1.out, if1.ocupado, if1.pronto};
    assign obs_w[2] = {if2.out, if2.ocupado, if2.pronto};
    assign obs_w[3] = {if3.out, if3.ocupado, if3.pronto};
    assign obs_w[4] = {if4.out, if4.ocupado, if4.pronto};

    transmissor_serial u0 (.clock(clock), .reset_n(rst_v[0]), .bus(if0));
    transmissor_serial #(.CLKS_PER_BIT(4), .PARITY(1)) u1 (.clock(clock), .reset_n(rst_v[1]), .bus(if1));
    transmissor_serial #(.CLKS_PER_BIT(4), .PARITY(2)) u2 (.clock(clock), .reset_n(rst_v[2]), .bus(if2));
    transmissor_serial #(.CLKS_PER_BIT(2), .PARITY(1), .STOP_BITS(2)) u3 (.clock(clock), .reset_n(rst_v[3]), .bus(if3));
    transmissor_serial #(.DATA_W(3), .INSTR_W(5), .CLKS_PER_BIT(3), .DEBOUNCE_CYCLES(1),
                         .PARITY(2), .STOP_BITS(2)) u4 (.clock(clock), .reset_n(rst_v[4]), .bus(if4));

    // Per-edge stimulus: index e is the value sampled by the e-th rising edge of a scenario
    logic       sb [MAXN];
    logic       sr [MAXN];
    logic [7:0] sd [MAXN];
    logic [7:0] si [MAXN];
    logic [2:0] expv [MAXN];
    logic [MAXN-1:0] got_out, got_ocup, got_pr;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stim();
        for (int e = 0; e < MAXN; e++) begin
            sb[e] = 1'b0; sr[e] = 1'b1; sd[e] = 8'h00; si[e] = 8'h00;
        end
        sr[0] = 1'b0;
    endtask

    // Behavioural expectation: a frame is the bit list start/payload/parity/stops, each
    // bit held CLKS_PER_BIT cycles, launched when DEBOUNCE_CYCLES consecutive highs are seen
    // while idle and re-armed only after a low sample following a held-through completion.
    task automatic model(input int idx, input int n);
        int   fs = -1;
        int   run = 0;
        int   flen = 0;
        bit   armed = 1'b1;
        logic bits[$];
        logic p;
        for (int e = 0; e < n; e++) begin
            if (!sr[e]) begin
                expv[e] = 3'b100; fs = -1; run = 0; armed = 1'b1;
            end else if (fs >= 0 && e < fs + flen) begin
                expv[e] = {bits[(e - fs) / ccpb[idx]], 2'b10};
            end else if (fs >= 0 && e == fs + flen) begin
                expv[e] = 3'b101; armed = !sb[e]; run = 0; fs = -1;
            end else if (!armed) begin
                expv[e] = 3'b100;
                if (!sb[e]) armed = 1'b1;
            end else if (sb[e]) begin
                run++;
                if (run == cdeb[idx]) begin
                    bits.delete();
                    bits.push_back(1'b0);
                    p = 1'b0;
                    for (int k = 0; k < cdw[idx]; k++) begin bits.push_back(sd[e][k]); p ^= sd[e][k]; end
                    for (int k = 0; k < ciw[idx]; k++) begin bits.push_back(si[e][k]); p ^= si[e][k]; end
                    if (cpar[idx] == 1) bits.push_back(p);
                    if (cpar[idx] == 2) bits.push_back(~p);
                    for (int k = 0; k < cstop[idx]; k++) bits.push_back(1'b1);
                    flen = ccpb[idx] * bits.size();
                    fs = e; run = 0;
                    expv[e] = 3'b010;
                end else begin
                    expv[e] = 3'b100;
                end
            end else begin
                run = 0; expv[e] = 3'b100;
            end
        end
    endtask

    task automatic run(input int idx, input string tag, input int n);
        logic [2:0] o;
        model(idx, n);
        got_out = '0; got_ocup = '0; got_pr = '0;
        for (int e = 0; e < n; e++) begin
            botao_v[idx] = sb[e]; rst_v[idx] = sr[e]; dado_v[idx] = sd[e]; instr_v[idx] = si[e];
            @(posedge clock);
            @(negedge clock);
            o = obs_w[idx];
            got_out[e] = o[2]; got_ocup[e] = o[1]; got_pr[e] = o[0];
            n_tests++;
            assert (o === expv[e]) else begin
                n_fail++;
                $error("FAIL %s edge %0d out/ocupado/pronto got %b expected %b", tag, e, o, expv[e]);
            end
        end
        botao_v[idx] = 1'b0; rst_v[idx] = 1'b1;
    endtask

    task automatic gen_random(input int n);
        logic       lvl;
        int         e;
        int         len;
        logic [7:0] cd, ci;
        clear_stim();
        lvl = 1'b0; e = 1;
        while (e < n) begin
            len = lvl ? $urandom_range(1, 14) : $urandom_range(1, 6);
            for (int k = 0; k < len && e < n; k++) begin sb[e] = lvl; e++; end
            lvl = !lvl;
        end
        cd = 8'($urandom); ci = 8'($urandom);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 9) == 0) cd = 8'($urandom);
            if ($urandom_range(0, 9) == 0) ci = 8'($urandom);
            sd[k] = cd; si[k] = ci;
            if (k > 0) sr[k] = ($urandom_range(0, 70) != 0);
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            botao_v[i] = 1'b0; rst_v[i] = 1'b0; dado_v[i] = 8'h00; instr_v[i] = 8'h00;
        end
        @(posedge clock); @(posedge clock); @(negedge clock);
        for (int i = 0; i < NI; i++) chk($sformatf("reset_state_u%0d", i), 32'(obs_w[i]), 32'h4);

        // Legacy frame A/5
        clear_stim();
        for (int e = 1; e <= 3; e++) sb[e] = 1'b1;
        for (int e = 0; e < 16; e++) begin sd[e] = 8'hA; si[e] = 8'h5; end
        run(0, "frame_a5", 16);
        chk("a5_line_bits", 32'(got_out[12:3]), 32'b1010110100);
        chk("a5_pronto_cycle11", 32'(got_pr[13]), 32'h1);
        chk("a5_ocupado_len", 32'($countones(got_ocup[15:0])), 32'd10);

        // Glitchy button never transmits
        clear_stim();
        sb[1] = 1; sb[2] = 1; sb[4] = 1; sb[5] = 1;
        run(0, "glitch", 16);
        chk("glitch_no_busy", 32'(got_ocup[15:0]), 32'h0);
        chk("glitch_no_pronto", 32'(got_pr[15:0]), 32'h0);

        // Held button: one frame, then release and re-press
        clear_stim();
        for (int e = 1; e <= 40; e++) sb[e] = 1'b1;
        for (int e = 46; e <= 48; e++) sb[e] = 1'b1;
        for (int e = 0; e < 80; e++) begin sd[e] = 8'h3; si[e] = 8'h9; end
        run(0, "held", 80);
        chk("held_pronto_count", 32'($countones(got_pr[79:0])), 32'd2);
        chk("held_first_pronto", 32'(got_pr[13]), 32'h1);

        // Parity, wide bits
        clear_stim();
        for (int e = 1; e <= 3; e++) sb[e] = 1'b1;
        for (int e = 0; e < 56; e++) begin sd[e] = 8'h7; si[e] = 8'h1; end
        run(1, "even_par", 56);
        chk("even_par_bit", 32'(got_out[42:39]), 32'h0);
        chk("even_par_len", 32'($countones(got_ocup[55:0])), 32'd44);
        chk("even_par_pronto", 32'(got_pr[47]), 32'h1);
        run(2, "odd_par", 56);
        chk("odd_par_bit", 32'(got_out[42:39]), 32'hF);
        chk("odd_par_len", 32'($countones(got_ocup[55:0])), 32'd44);

        // Payload change mid-frame is ignored; two stop bits
        clear_stim();
        for (int e = 1; e <= 3; e++) sb[e] = 1'b1;
        for (int e = 0; e < 34; e++) begin sd[e] = (e >= 7) ? 8'hC : 8'h3; si[e] = 8'h6; end
        run(3, "latch_hold", 34);
        chk("latched_dado", 32'({got_out[11], got_out[9], got_out[7], got_out[5]}), 32'h3);
        chk("stop_high", 32'(got_out[26:23]), 32'hF);
        chk("frame24_len", 32'($countones(got_ocup[33:0])), 32'd24);

        // Reset mid-frame aborts silently; new debounce needed
        clear_stim();
        for (int e = 1; e <= 3; e++) sb[e] = 1'b1;
        sr[8] = 1'b0;
        for (int e = 20; e <= 22; e++) sb[e] = 1'b1;
        for (int e = 0; e < 40; e++) begin sd[e] = 8'h5; si[e] = 8'hE; end
        run(0, "abort", 40);
        chk("abort_line", 32'({got_out[8], got_ocup[8]}), 32'h2);
        chk("abort_no_pronto", 32'(got_pr[31:0]), 32'h0);
        chk("abort_refire", 32'(got_pr[32]), 32'h1);

        // Randomised traffic
        gen_random(200); run(4, "rand_u4a", 200);
        gen_random(200); run(4, "rand_u4b", 200);
        gen_random(200); run(0, "rand_u0", 200);
        gen_random(200); run(3, "rand_u3", 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
